// File: rtl/d_ff_pkg.sv
// Shared constants for the d_ff register chain.
package d_ff_pkg;

    localparam int D_FF_MAX_STAGES    = 8;
    localparam int D_FF_DEFAULT_WIDTH = 1;

    function automatic bit d_ff_stages_ok(input int stages);
        return (stages >= 1) && (stages <= D_FF_MAX_STAGES);
    endfunction

endpackage

// File: rtl/d_ff_stage.sv
// One WIDTH-bit register with asynchronous active-low reset to RESET_VALUE.
module d_ff_stage
    import d_ff_pkg::*;
#(
    parameter int               WIDTH       = D_FF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    assign q_d = d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/d_ff.sv
// Parameterised D flip-flop chain of STAGES registers with complemented output.
// Define D_FF_ASSERT_EN to compile in simulation-only checks.
module d_ff
    import d_ff_pkg::*;
#(
    parameter int               WIDTH       = D_FF_DEFAULT_WIDTH,
    parameter int               STAGES      = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    input  tri1              rst_n
);

    // chain[0] is the input; chain[k+1] is the output of stage k.
    logic [STAGES:0][WIDTH-1:0] chain;

    assign chain[0] = d;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        d_ff_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (chain[k]),
            .q     (chain[k+1])
        );
    end

    assign q     = chain[STAGES];
    assign q_bar = ~q;

`ifdef D_FF_ASSERT_EN
    if (!d_ff_stages_ok(STAGES)) begin : g_bad_stages
        $fatal(1, "d_ff: STAGES=%0d outside 1..%0d", STAGES, D_FF_MAX_STAGES);
    end

    // Counts rising edges from time 0 so the input X check skips pipeline fill.
    int unsigned edge_cnt_q = 0;

    always @(posedge clk) begin
        if (edge_cnt_q < $unsigned(STAGES)) begin
            edge_cnt_q <= edge_cnt_q + 1;
        end
        assert (q_bar === ~q)
            else $error("d_ff: q_bar=%h is not ~q (q=%h)", q_bar, q);
        if (rst_n === 1'b0) begin
            assert (q === RESET_VALUE)
                else $error("d_ff: q=%h during reset, want %h", q, RESET_VALUE);
        end
        if ((rst_n === 1'b1) && (edge_cnt_q >= $unsigned(STAGES))) begin
            assert (!$isunknown(d))
                else $error("d_ff: unknown d=%h at rising edge", d);
        end
    end
`endif

endmodule

// File: tb/tb_d_ff.sv
// Directed + randomized bench for d_ff across several parameterisations.
module tb_d_ff;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst1_n = 1'b1;
    logic       rst_n  = 1'b0;
    logic       d1;
    logic [7:0] d8, d3;
    logic [3:0] dc;
    logic       q1, q1_bar;
    logic [7:0] q8, q8_bar, q3, q3_bar;
    logic [3:0] qc, qc_bar;

    d_ff #(.WIDTH(1), .STAGES(1)) u_dut1 (
        .clk(clk), .d(d1), .q(q1), .q_bar(q1_bar), .rst_n(rst1_n));
    d_ff #(.WIDTH(8), .STAGES(1)) u_dut8 (
        .clk(clk), .d(d8), .q(q8), .q_bar(q8_bar), .rst_n(rst_n));
    d_ff #(.WIDTH(8), .STAGES(3)) u_dut3 (
        .clk(clk), .d(d3), .q(q3), .q_bar(q3_bar), .rst_n(rst_n));
    d_ff #(.WIDTH(4), .STAGES(2), .RESET_VALUE(4'hC)) u_dutc (
        .clk(clk), .d(dc), .q(qc), .q_bar(qc_bar), .rst_n(rst_n));

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference: history of values sampled at accepted rising edges, newest
    // first; the output of an N-stage chain is the sample taken N edges ago.
    logic       h1[$];
    logic [7:0] h8[$];
    logic [7:0] h3[$];
    logic [3:0] hc[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
            else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
            end
    endtask

    task automatic model_reset();
        h8 = '{8'h00};
        h3 = '{8'h00, 8'h00, 8'h00};
        hc = '{4'hC, 4'hC};
    endtask

    task automatic model_edge();
        h1.push_front(d1);
        void'(h1.pop_back());
        if (rst_n) begin
            h8.push_front(d8); void'(h8.pop_back());
            h3.push_front(d3); void'(h3.pop_back());
            hc.push_front(dc); void'(hc.pop_back());
        end
    endtask

    task automatic check_all(input string tag);
        logic       e1, e1b;
        logic [7:0] e8, e8b, e3, e3b;
        logic [3:0] ec, ecb;
        e1 = h1[$]; e1b = ~e1;
        e8 = h8[$]; e8b = ~e8;
        e3 = h3[$]; e3b = ~e3;
        ec = hc[$]; ecb = ~ec;
        chk({tag, ".q1"},     q1,     e1);
        chk({tag, ".q1_bar"}, q1_bar, e1b);
        chk({tag, ".q8"},     q8,     e8);
        chk({tag, ".q8_bar"}, q8_bar, e8b);
        chk({tag, ".q3"},     q3,     e3);
        chk({tag, ".q3_bar"}, q3_bar, e3b);
        chk({tag, ".qc"},     qc,     ec);
        chk({tag, ".qc_bar"}, qc_bar, ecb);
    endtask

    // One clock period: drive at the falling edge with a short glitch first,
    // optionally pulse reset mid-cycle, then check after the rising edge.
    task automatic tick(input logic v1, input logic [7:0] v8, input logic [7:0] v3,
                        input logic [3:0] vc, input bit do_rst);
        @(negedge clk);
        d1 = ~v1; d8 = ~v8; d3 = ~v3; dc = ~vc;
        #2;
        d1 = v1; d8 = v8; d3 = v3; dc = vc;
        if (do_rst) begin
            #1 rst_n = 1'b0;
            model_reset();
            #1 check_all("rst_async");
        end else begin
            #3 check_all("hold");
        end
        @(posedge clk);
        model_edge();
        #1 check_all("edge");
        if (do_rst) begin
            #4 rst_n = 1'b1;
        end
    endtask

    initial begin
        d1 = 1'b0; d8 = 8'h00; d3 = 8'h00; dc = 4'h0;
        model_reset();

        // Fixed timeline for the single-bit flop with reset never asserted.
        #5  d1 = 1'b1;
        #6  chk("t11.q1", q1, 8'h01);
            chk("t11.q1_bar", q1_bar, 8'h00);
            chk("t11.q8_rst", q8, 8'h00);
            chk("t11.q8_bar_rst", q8_bar, 8'hFF);
            chk("t11.qc_rst", qc, 8'h0C);
            chk("t11.qc_bar_rst", qc_bar, 8'h03);
        #4  d1 = 1'b0;
        #3  d1 = 1'b1;
        #2  chk("t20.q1_falling", q1, 8'h01);
        #1  d1 = 1'b0;
        #8  chk("t29.q1_noglitch", q1, 8'h01);
        #2  chk("t31.q1", q1, 8'h00);
            chk("t31.q1_bar", q1_bar, 8'h01);
        #4  d1 = 1'b1;
        #16 chk("t51.q1", q1, 8'h01);
            chk("t51.q1_bar", q1_bar, 8'h00);
        #1  rst_n = 1'b1;
        h1 = '{1'b1};

        // Capture A5, then reset mid-cycle: output must clear at once.
        tick(1'b1, 8'hA5, 8'h00, 4'h5, 1'b0);
        chk("a5.q8", q8, 8'hA5);
        tick(1'b0, 8'h3C, 8'h00, 4'h6, 1'b1);

        // Held input of 1 shows on q only after the next rising edge.
        tick(1'b0, 8'h11, 8'h00, 4'h1, 1'b0);
        tick(1'b1, 8'h22, 8'h00, 4'h2, 1'b0);
        tick(1'b1, 8'h33, 8'h00, 4'h3, 1'b0);

        // One-cycle pulse through the 3-stage chain.
        tick(1'b0, 8'h44, 8'h01, 4'h4, 1'b0);
        chk("pulse.e0", q3, 8'h00);
        tick(1'b0, 8'h55, 8'h00, 4'h5, 1'b0);
        chk("pulse.e1", q3, 8'h00);
        tick(1'b0, 8'h66, 8'h00, 4'h6, 1'b0);
        chk("pulse.e2", q3, 8'h01);
        tick(1'b0, 8'h77, 8'h00, 4'h7, 1'b0);
        chk("pulse.e3", q3, 8'h00);

        for (int i = 0; i < 80; i++) begin
            tick(1'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                 ($urandom_range(0, 9) == 0));
        end

        // Reset-value check for the non-zero reset pattern.
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 chk("rv.qc", qc, 8'h0C);
           chk("rv.qc_bar", qc_bar, 8'h03);
           chk("rv.q3", q3, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
